// File: rtl/zeroriscy_slv_arb.sv
// zeroriscy_slv_arb
// Shares one zero-riscy req/gnt/rvalid slave port between two masters
// (m0 = instruction, m1 = data). Round-robin arbitration with a bounded
// number of accepted-but-unanswered transactions. Response routing uses a
// small FIFO of master IDs, which relies on the slave answering in request
// order.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   mX_req/we/be/addr/wdata     master X request channel (in)
//   mX_gnt                      master X grant, zero latency (out)
//   mX_rvalid                   master X response valid (out)
//   mX_rdata/err                slave response, broadcast to both (out)
//   s_req/we/be/addr/wdata      slave request channel (out)
//   s_gnt                       slave grant (in)
//   s_rvalid/rdata/err          slave response, in request order (in)
//   prot_err                    sticky: rvalid seen with nothing outstanding
module zeroriscy_slv_arb #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic        s_err,
  output logic        prot_err
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [CW-1:0]          r_cnt;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [OUTSTANDING-1:0] r_fifo;
  logic                   r_last;
  logic                   r_prot_err;

  logic w_full;
  logic w_sel;
  logic w_any_req;
  logic w_accept;
  logic w_pop;
  logic w_head;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot early and s_rvalid has no path into s_req or the grants.
  assign w_full    = (r_cnt == CW'(OUTSTANDING));
  assign w_any_req = m0_req | m1_req;

  always_comb begin
    w_sel = r_last;
    if (m0_req && !m1_req)      w_sel = 1'b0;
    else if (!m0_req && m1_req) w_sel = 1'b1;
    else if (m0_req && m1_req)  w_sel = ~r_last;
  end

  assign s_req = w_any_req & ~w_full;

  always_comb begin
    s_we    = 1'b0;
    s_be    = 4'h0;
    s_addr  = 32'h0;
    s_wdata = 32'h0;
    if (s_req) begin
      s_we    = w_sel ? m1_we    : m0_we;
      s_be    = w_sel ? m1_be    : m0_be;
      s_addr  = w_sel ? m1_addr  : m0_addr;
      s_wdata = w_sel ? m1_wdata : m0_wdata;
    end
  end

  assign w_accept = s_req & s_gnt;
  assign m0_gnt   = w_accept & ~w_sel;
  assign m1_gnt   = w_accept & w_sel;

  // A response with nothing outstanding is dropped and flagged instead.
  assign w_pop     = s_rvalid & (r_cnt != '0);
  assign w_head    = r_fifo[r_rd_ptr];
  assign m0_rvalid = w_pop & ~w_head;
  assign m1_rvalid = w_pop & w_head;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_err    = s_err;
  assign m1_err    = s_err;
  assign prot_err  = r_prot_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo     <= '0;
      r_last     <= 1'b1;
      r_prot_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr <= (r_wr_ptr == PW'(OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_last   <= w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (s_rvalid && (r_cnt == '0)) begin
        r_prot_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_slv_arb.sv
module tb_zeroriscy_slv_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_gnt, s_rvalid, s_err, prot_err;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  zeroriscy_slv_arb #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .prot_err(prot_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // inputs are driven 1 time unit after the rising edge, sampled 3 later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  // grant check; on an expected grant the owner ID goes to the scoreboard
  task automatic gnt_chk(input string tag, input logic g0, input logic g1);
    chk({tag, "_gnt0"}, m0_gnt, g0);
    chk({tag, "_gnt1"}, m1_gnt, g1);
    if (g0) exp_q.push_back(1'b0);
    if (g1) exp_q.push_back(1'b1);
  endtask

  // response check against the scoreboard head; call with s_rvalid driven
  task automatic resp_chk(input string tag);
    bit id;
    if (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      chk({tag, "_rv0"}, m0_rvalid, id == 1'b0);
      chk({tag, "_rv1"}, m1_rvalid, id == 1'b1);
      chk({tag, "_rdata"}, id ? m1_rdata : m0_rdata, s_rdata);
      chk({tag, "_err"}, id ? m1_err : m0_err, s_err);
    end else begin
      chk({tag, "_rv0_none"}, m0_rvalid, 1'b0);
      chk({tag, "_rv1_none"}, m1_rvalid, 1'b0);
    end
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 0; m1_wdata = 0;
    s_gnt = 1; s_rvalid = 0; s_rdata = 0; s_err = 0;
  endtask

  task automatic drain(input string tag, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      cyc();
      s_rvalid = 1; s_rdata = base + 32'(i);
      smp();
      resp_chk(tag);
    end
    cyc();
    s_rvalid = 0;
  endtask

  initial begin
    reset = 1;
    idle_in();
    #4;
    chk("rst_sreq", s_req, 0);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_rv0", m0_rvalid, 0);
    chk("rst_rv1", m1_rvalid, 0);
    chk("rst_prot", prot_err, 0);
    cyc();
    reset = 0;

    // 1: simultaneous requests after reset, m0 wins the first tie
    cyc();
    m0_req = 1; m0_addr = 32'h8010_0000;
    m1_req = 1; m1_addr = 32'h8010_0004;
    smp();
    chk("t1_addr0", s_addr, 32'h8010_0000);
    gnt_chk("t1a", 1, 0);
    cyc();
    m0_req = 0; s_rvalid = 1; s_rdata = 32'hAAAA_0000;
    smp();
    chk("t1_addr1", s_addr, 32'h8010_0004);
    gnt_chk("t1b", 0, 1);
    resp_chk("t1_r0");
    cyc();
    m1_req = 0; s_rdata = 32'hBBBB_0000;
    smp();
    chk("t1_sreq_idle", s_req, 0);
    resp_chk("t1_r1");
    cyc();
    s_rvalid = 0;

    // 2: m1 alone, three requests against a depth of two
    m1_req = 1; m1_addr = 32'h0000_1000;
    smp();
    gnt_chk("t2a", 0, 1);
    cyc();
    smp();
    gnt_chk("t2b", 0, 1);
    cyc();
    smp();
    chk("t2_full_sreq", s_req, 0);
    gnt_chk("t2c", 0, 0);
    cyc();
    s_rvalid = 1; s_rdata = 32'h0000_2222;
    smp();
    gnt_chk("t2_pop_nogrant", 0, 0);
    resp_chk("t2_r0");
    cyc();
    s_rvalid = 0;
    smp();
    gnt_chk("t2_third", 0, 1);

    // 3: full, pop plus new m0 request in the same cycle
    cyc();
    m1_req = 0; m0_req = 1; m0_addr = 32'h0000_3000;
    s_rvalid = 1; s_rdata = 32'h0000_3333;
    smp();
    chk("t3_full_sreq", s_req, 0);
    gnt_chk("t3_nogrant", 0, 0);
    resp_chk("t3_r0");
    cyc();
    s_rvalid = 0;
    smp();
    gnt_chk("t3_grant", 1, 0);
    cyc();
    m0_req = 0;
    smp();
    chk("t3_full_again", s_req, 0);
    drain("t3_drain", 2, 32'h0000_3400);

    // single m1 transaction so the last owner is m1 again
    m1_req = 1; m1_addr = 32'h0000_4000;
    smp();
    gnt_chk("t4_pre", 0, 1);
    cyc();
    m1_req = 0;
    drain("t4_pre_r", 1, 32'h0000_4100);

    // 4: slave stall with both requesting
    m0_req = 1; m0_addr = 32'h0000_5000;
    m1_req = 1; m1_addr = 32'h0000_5004;
    s_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t4_stall_sreq", s_req, 1);
      chk("t4_stall_addr", s_addr, 32'h0000_5000);
      gnt_chk("t4_stall", 0, 0);
      cyc();
    end
    s_gnt = 1;
    smp();
    gnt_chk("t4_rel", 1, 0);
    cyc();
    smp();
    chk("t4_addr_m1", s_addr, 32'h0000_5004);
    gnt_chk("t4_alt", 0, 1);
    cyc();
    m0_req = 0; m1_req = 0;
    drain("t4_drain", 2, 32'h0000_5100);

    // 5: m1 write with an error response
    m1_req = 1; m1_we = 1; m1_be = 4'b0011;
    m1_addr = 32'h0000_6000; m1_wdata = 32'h1234_5678;
    smp();
    chk("t5_we", s_we, 1);
    chk("t5_be", s_be, 4'b0011);
    chk("t5_wdata", s_wdata, 32'h1234_5678);
    gnt_chk("t5", 0, 1);
    cyc();
    m1_req = 0; m1_we = 0;
    s_rvalid = 1; s_rdata = 32'h0000_6666; s_err = 1;
    smp();
    chk("t5_be_gated", s_be, 0);
    resp_chk("t5_r");
    cyc();
    s_rvalid = 0; s_err = 0;

    // 6: reset with two outstanding, late response flags prot_err
    m0_req = 1; m0_addr = 32'h0000_7000;
    m1_req = 1; m1_addr = 32'h0000_7004;
    smp();
    gnt_chk("t6a", 1, 0);
    cyc();
    smp();
    gnt_chk("t6b", 0, 1);
    cyc();
    m0_req = 0; m1_req = 0;
    reset = 1;
    exp_q.delete();
    smp();
    chk("t6_rst_prot", prot_err, 0);
    cyc();
    reset = 0;
    cyc();
    s_rvalid = 1; s_rdata = 32'h0000_7777;
    smp();
    resp_chk("t6_late");
    cyc();
    s_rvalid = 0;
    smp();
    chk("t6_prot_set", prot_err, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      chk("t6_prot_sticky", prot_err, 1);
    end
    cyc();
    reset = 1;
    smp();
    chk("t6_prot_clr", prot_err, 0);
    cyc();
    reset = 0;

    if (exp_q.size() != 0) begin
      chk("sb_leftover", 32'(exp_q.size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
